multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 8, width of the retired-instruction counter.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 iRST_N  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; 1 = free-run, 0 = single-step mode.
REQ-005 step  input  1  level from debounced key; rising edge requests one instruction.
REQ-006 op  input  6  instruction[31:26] from ROM.
REQ-007 funct  input  6  instruction[5:0] from ROM.
REQ-008 zero  input  1  ULA zero flag.
REQ-009 ir_we, pc_we, pc_src  output  1 each  IR load, PC update, PC branch select.
REQ-010 reg_write, reg_dst, ula_src, mem_write, mem_to_reg  output  1 each  datapath controls.
REQ-011 ula_control  output  3  ULA operation.
REQ-012 busy, illegal  output  1 each  instruction in flight; sticky illegal-opcode flag.
REQ-013 state  output  3  current state encoding, debug.
REQ-014 instr_count  output  CNT_W  retired instructions.

Function
REQ-015 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-016 IDLE->FETCH when run=1 or a step rising edge is detected, else stay.
REQ-017 Step edge detection SHALL use a registered copy of step; edges arriving outside IDLE are discarded, not queued.
REQ-018 FETCH: ir_we=1, pc_we=1, pc_src=0 for one cycle; ->DECODE; op/funct captured into internal registers.
REQ-019 DECODE: classify captured op/funct; unsupported op, or R-type with unsupported funct, ->HALT with illegal=1; otherwise ->EXEC.
REQ-020 Supported: R-type (op 000000, funct add 100000, sub 100010, and 100100, or 100101, slt 101010), addi 001000, lw 100011, sw 101011, beq 000100.
REQ-021 ula_control SHALL be: add 010, sub 110, and 000, or 001, slt 111; addi/lw/sw use 010; beq uses 110; 010 in all non-EXEC/MEM/WB states.
REQ-022 EXEC: ula_src=1 for addi/lw/sw, 0 otherwise; R-type/addi ->WB; lw/sw ->MEM; beq asserts pc_we=zero, pc_src=1, then retires.
REQ-023 MEM: sw asserts mem_write=1 and retires; lw ->WB.
REQ-024 WB: reg_write=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw; then retires.
REQ-025 Retire: instr_count increments by 1 (wraps at 2^CNT_W-1 -> 0); next state FETCH if run=1, else IDLE.
REQ-026 Latency from FETCH: beq 3, R-type/addi/sw 4, lw 5 cycles.
REQ-027 All control outputs SHALL depend only on state and captured instruction registers, never combinationally on op/funct/run/step; zero is the sole exception (beq pc_we).
REQ-028 busy=1 in FETCH..WB, 0 in IDLE and HALT.
REQ-029 HALT SHALL be left only by reset; all write enables 0 in HALT.
REQ-030 run dropping mid-instruction SHALL complete the instruction, then enter IDLE.

Reset
REQ-031 iRST_N low SHALL immediately force state=IDLE, all enables 0, ula_control=010, illegal=0, instr_count=0, step edge register=0, regardless of clk, including mid-instruction.

Configuration
REQ-032 Macro MC_BRANCH_EN: defined -> beq supported per REQ-022; undefined -> op 000100 treated as illegal and pc_src tied 0.

Structure
REQ-033 Package mc_pkg SHALL hold the state encoding, opcode, funct and ula_control constants.
REQ-034 One sub-module, mc_alu_decoder, SHALL map captured instruction class and funct to ula_control combinationally.

Verification
REQ-035 Reset, run=1, R-type add (op 000000, funct 100000) -> states 1,2,3,5,1; reg_write=1, reg_dst=1, ula_control=010 in WB; instr_count=1.
REQ-036 run=0, lw then one step edge -> 5-cycle sequence with mem_to_reg=1 in WB, then IDLE; second edge during busy ignored, instr_count=1.
REQ-037 beq with zero=1 -> pc_we=1, pc_src=1 in EXEC; zero=0 -> pc_we=0; without MC_BRANCH_EN -> HALT, illegal=1.
REQ-038 op 111111 -> HALT after DECODE, illegal=1, busy=0; run/step ignored until iRST_N pulse clears to IDLE.
REQ-039 Preload instr_count to 255 via 255 sw retirements -> next retirement wraps to 0; iRST_N asserted in MEM -> mem_write drops asynchronously, state=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multicycle_control block.
//
// Holds the FSM state encoding, the supported opcode / funct values, the
// ula_control operation codes and the instruction-class type used between
// the controller and its ALU decoder.
//
// Optional feature macro: MC_BRANCH_EN
//   defined   -> beq (op 000100) is a supported instruction
//   undefined -> beq is classified as illegal
// ---------------------------------------------------------------------------
package mc_pkg;

    // FSM state encoding; values are visible on the debug state output.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction class derived from the captured op/funct.
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ULA operation codes
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_AND) || (funct == FUNCT_OR)  ||
               (funct == FUNCT_SLT);
    endfunction

    // Map an op/funct pair to its class; anything unsupported is illegal.
    function automatic instr_class_t classify(input logic [5:0] op,
                                              input logic [5:0] funct);
        instr_class_t cls;
        case (op)
            OP_RTYPE: cls = funct_supported(funct) ? CLS_RTYPE : CLS_ILLEGAL;
            OP_ADDI:  cls = CLS_ADDI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
`ifdef MC_BRANCH_EN
            OP_BEQ:   cls = CLS_BEQ;
`else
            OP_BEQ:   cls = CLS_ILLEGAL;
`endif
            default:  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if -- controller <-> datapath bundle.
//
// Datapath to controller: op, funct (from the instruction ROM), zero (ULA).
// Controller to datapath: ir_we, pc_we, pc_src, reg_write, reg_dst,
//                         ula_src, mem_write, mem_to_reg, ula_control.
//
// Modports:
//   master -- the controller (drives control lines)
//   slave  -- the datapath   (drives op/funct/zero)
// ---------------------------------------------------------------------------
interface multicycle_control_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       ula_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] ula_control;

    modport master (
        input  op, funct, zero,
        output ir_we, pc_we, pc_src, reg_write, reg_dst,
               ula_src, mem_write, mem_to_reg, ula_control
    );

    modport slave (
        output op, funct, zero,
        input  ir_we, pc_we, pc_src, reg_write, reg_dst,
               ula_src, mem_write, mem_to_reg, ula_control
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder -- combinational ULA operation select.
//
// Ports:
//   cls         in   instruction class of the captured instruction
//   funct       in   captured funct field (used only for R-type)
//   ula_control out  ULA operation code
//
// The caller decides in which states this result is actually presented.
// ---------------------------------------------------------------------------
module mc_alu_decoder
    import mc_pkg::*;
(
    input  instr_class_t cls,
    input  logic [5:0]   funct,
    output logic [2:0]   ula_control
);

    always_comb begin
        ula_control = ULA_ADD;
        case (cls)
            CLS_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ula_control = ULA_ADD;
                    FUNCT_SUB: ula_control = ULA_SUB;
                    FUNCT_AND: ula_control = ULA_AND;
                    FUNCT_OR:  ula_control = ULA_OR;
                    FUNCT_SLT: ula_control = ULA_SLT;
                    default:   ula_control = ULA_ADD;
                endcase
            end
            CLS_ADDI, CLS_LW, CLS_SW: ula_control = ULA_ADD;
            CLS_BEQ:                  ula_control = ULA_SUB;
            default:                  ula_control = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control -- FSM controller for a small multicycle MIPS-like core.
//
// Ports:
//   clk          in   system clock, rising edge
//   iRST_N       in   asynchronous active-low reset
//   run          in   1 = free-run, 0 = single-step
//   step         in   debounced key; a rising edge in IDLE starts one instr
//   dp           if   datapath bundle (master side): op/funct/zero in,
//                     write enables, muxes and ula_control out
//   busy         out  instruction in flight (FETCH..WB)
//   illegal      out  sticky illegal-instruction flag
//   state        out  current state encoding (debug)
//   instr_count  out  retired-instruction counter, CNT_W bits, wraps
//
// Optional feature macro: MC_BRANCH_EN (beq support; pc_src tied 0 without).
//
// All control outputs are decoded from the state register and the op/funct
// copies captured in FETCH, so ROM glitches cannot reach the datapath. The
// only combinational input path is zero -> pc_we during a beq EXEC.
// ---------------------------------------------------------------------------
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              iRST_N,
    input  logic              run,
    input  logic              step,
    multicycle_control_if.master dp,
    output logic              busy,
    output logic              illegal,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  instr_count
);

    state_t             state_reg, state_next;
    logic [5:0]         op_reg, funct_reg;
    logic               step_reg;
    logic               illegal_reg;
    logic [CNT_W-1:0]   count_reg;

    instr_class_t       cls;
    logic [2:0]         dec_ula;
    logic               step_rise;
    logic               retire;

    logic               ir_we, pc_we, pc_src, reg_write, reg_dst;
    logic               ula_src, mem_write, mem_to_reg;

    assign cls       = classify(op_reg, funct_reg);
    assign step_rise = step & ~step_reg;

    mc_alu_decoder u_alu_decoder (
        .cls         (cls),
        .funct       (funct_reg),
        .ula_control (dec_ula)
    );

    // ---------------------------------------------------------------
    // State and captured-instruction registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg   <= S_IDLE;
            op_reg      <= '0;
            funct_reg   <= '0;
            step_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // step is tracked every cycle, so edges seen outside IDLE
            // are consumed here and never replayed later.
            step_reg  <= step;
            if (state_reg == S_FETCH) begin
                op_reg    <= dp.op;
                funct_reg <= dp.funct;
            end
            if ((state_reg == S_DECODE) && (cls == CLS_ILLEGAL))
                illegal_reg <= 1'b1;
            if (retire)
                count_reg <= count_reg + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Next state and control outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        ula_src    = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run || step_rise)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = (cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ula_src = (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
                case (cls)
                    CLS_RTYPE, CLS_ADDI: state_next = S_WB;
                    CLS_LW, CLS_SW:      state_next = S_MEM;
`ifdef MC_BRANCH_EN
                    CLS_BEQ: begin
                        pc_we  = dp.zero;
                        pc_src = 1'b1;
                        retire = 1'b1;
                    end
`endif
                    default:             state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                if (cls == CLS_SW) begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == CLS_RTYPE);
                mem_to_reg = (cls == CLS_LW);
                retire     = 1'b1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // run is sampled only at retirement so a run drop finishes the
        // current instruction before parking in IDLE.
        if (retire)
            state_next = run ? S_FETCH : S_IDLE;
    end

`ifndef MC_BRANCH_EN
    // zero only matters for beq; keep it visibly consumed.
    logic unused_zero;
    assign unused_zero = dp.zero;
`endif

    // ULA code is only meaningful while the instruction is executing.
    always_comb begin
        dp.ula_control = ULA_ADD;
        if ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB))
            dp.ula_control = dec_ula;
    end

    assign dp.ir_we      = ir_we;
    assign dp.pc_we      = pc_we;
    assign dp.pc_src     = pc_src;
    assign dp.reg_write  = reg_write;
    assign dp.reg_dst    = reg_dst;
    assign dp.ula_src    = ula_src;
    assign dp.mem_write  = mem_write;
    assign dp.mem_to_reg = mem_to_reg;

    assign busy        = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                         (state_reg == S_EXEC)  || (state_reg == S_MEM)    ||
                         (state_reg == S_WB);
    assign illegal     = illegal_reg;
    assign state       = state_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control -- directed bench for multicycle_control.
// Expected values are hand-derived from the state sequence of each
// instruction class. beq expectations depend on MC_BRANCH_EN.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk;
    logic       iRST_N;
    logic       run;
    logic       step;
    logic       busy;
    logic       illegal;
    logic [2:0] state;
    logic [7:0] instr_count;

    int errors = 0;
    int checks = 0;

    multicycle_control_if dp_if ();

    multicycle_control #(.CNT_W(8)) dut (
        .clk         (clk),
        .iRST_N      (iRST_N),
        .run         (run),
        .step        (step),
        .dp          (dp_if),
        .busy        (busy),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Synchronous-looking reset pulse; checks the reset state.
    task automatic do_reset();
        @(negedge clk);
        iRST_N = 1'b0;
        @(negedge clk);
        check_val("rst_state", state, 0);
        check_val("rst_count", instr_count, 0);
        check_val("rst_illegal", illegal, 0);
        check_val("rst_ula", dp_if.ula_control, 3'b010);
        check_val("rst_busy", busy, 0);
        iRST_N = 1'b1;
        tick();
    endtask

    // Called at a negedge in IDLE; returns at the negedge where FETCH shows.
    task automatic step_pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    logic [5:0] funct_tbl [5];
    logic [2:0] ula_tbl   [5];

    initial begin
        iRST_N = 1'b1;
        run    = 1'b0;
        step   = 1'b0;
        dp_if.op    = 6'b000000;
        dp_if.funct = 6'b100000;
        dp_if.zero  = 1'b0;

        funct_tbl[0] = 6'b100000; ula_tbl[0] = 3'b010;
        funct_tbl[1] = 6'b100010; ula_tbl[1] = 3'b110;
        funct_tbl[2] = 6'b100100; ula_tbl[2] = 3'b000;
        funct_tbl[3] = 6'b100101; ula_tbl[3] = 3'b001;
        funct_tbl[4] = 6'b101010; ula_tbl[4] = 3'b111;

        // ---- free-run add: 1,2,3,5,1 then run drop completes instr ----
        do_reset();
        check_val("idle_hold", state, 0);
        run = 1'b1;
        tick();
        check_val("add_fetch", state, 1);
        check_val("add_ir_we", dp_if.ir_we, 1);
        check_val("add_pc_we", dp_if.pc_we, 1);
        check_val("add_busy", busy, 1);
        tick();
        check_val("add_decode", state, 2);
        tick();
        check_val("add_exec", state, 3);
        check_val("add_exec_src", dp_if.ula_src, 0);
        tick();
        check_val("add_wb", state, 5);
        check_val("add_wb_rw", dp_if.reg_write, 1);
        check_val("add_wb_dst", dp_if.reg_dst, 1);
        check_val("add_wb_ula", dp_if.ula_control, 3'b010);
        tick();
        check_val("add_refetch", state, 1);
        check_val("add_count", instr_count, 1);
        run = 1'b0;
        tick(); tick(); tick();
        check_val("rundrop_wb", state, 5);
        tick();
        check_val("rundrop_idle", state, 0);
        check_val("rundrop_count", instr_count, 2);
        $display("txn add free-run count=%0d", instr_count);

        // ---- lw in single-step, second edge while busy ignored ----
        do_reset();
        dp_if.op = 6'b100011;
        step_pulse();
        check_val("lw_fetch", state, 1);
        tick();
        check_val("lw_decode", state, 2);
        step = 1'b1;
        tick();
        check_val("lw_exec", state, 3);
        check_val("lw_exec_src", dp_if.ula_src, 1);
        tick();
        check_val("lw_mem", state, 4);
        check_val("lw_mem_we", dp_if.mem_write, 0);
        tick();
        check_val("lw_wb", state, 5);
        check_val("lw_wb_m2r", dp_if.mem_to_reg, 1);
        check_val("lw_wb_dst", dp_if.reg_dst, 0);
        tick();
        check_val("lw_idle", state, 0);
        tick();
        check_val("lw_no_requeue", state, 0);
        check_val("lw_count", instr_count, 1);
        step = 1'b0;
        $display("txn lw step count=%0d", instr_count);

        // ---- R-type ULA table and addi ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dp_if.op    = 6'b000000;
            dp_if.funct = funct_tbl[i];
            step_pulse();
            tick(); tick();
            check_val("rtype_exec_ula", dp_if.ula_control, ula_tbl[i]);
            tick();
            check_val("rtype_wb_ula", dp_if.ula_control, ula_tbl[i]);
            tick();
            check_val("rtype_idle", state, 0);
            check_val("rtype_count", instr_count, i + 1);
            $display("txn rtype funct=%b", funct_tbl[i]);
        end
        dp_if.op = 6'b001000;
        step_pulse();
        tick(); tick();
        check_val("addi_src", dp_if.ula_src, 1);
        tick();
        check_val("addi_wb_dst", dp_if.reg_dst, 0);
        check_val("addi_wb_rw", dp_if.reg_write, 1);
        tick();
        check_val("addi_count", instr_count, 6);
        $display("txn addi");

        // ---- beq ----
        do_reset();
        dp_if.op   = 6'b000100;
        dp_if.zero = 1'b1;
        step_pulse();
        tick(); tick();
`ifdef MC_BRANCH_EN
        check_val("beq_exec", state, 3);
        check_val("beq_pc_we", dp_if.pc_we, 1);
        check_val("beq_pc_src", dp_if.pc_src, 1);
        check_val("beq_ula", dp_if.ula_control, 3'b110);
        dp_if.zero = 1'b0;
        #1;
        check_val("beq_nz_pc_we", dp_if.pc_we, 0);
        tick();
        check_val("beq_retire", state, 0);
        check_val("beq_count", instr_count, 1);
`else
        check_val("beq_halt", state, 6);
        check_val("beq_illegal", illegal, 1);
        check_val("beq_pc_src", dp_if.pc_src, 0);
`endif
        $display("txn beq");

        // ---- unsupported R-type funct ----
        do_reset();
        dp_if.op    = 6'b000000;
        dp_if.funct = 6'b000001;
        step_pulse();
        tick(); tick();
        check_val("badfunct_halt", state, 6);
        check_val("badfunct_illegal", illegal, 1);
        $display("txn bad funct");

        // ---- illegal opcode: HALT sticks until reset ----
        do_reset();
        dp_if.op = 6'b111111;
        step_pulse();
        tick();
        check_val("ill_decode", state, 2);
        tick();
        check_val("ill_halt", state, 6);
        check_val("ill_flag", illegal, 1);
        check_val("ill_busy", busy, 0);
        check_val("ill_pc_we", dp_if.pc_we, 0);
        check_val("ill_ir_we", dp_if.ir_we, 0);
        run = 1'b1;
        step_pulse();
        tick(); tick(); tick();
        check_val("ill_stuck", state, 6);
        run = 1'b0;
        #2;
        iRST_N = 1'b0;
        #1;
        check_val("ill_async_state", state, 0);
        check_val("ill_async_flag", illegal, 0);
        tick();
        iRST_N = 1'b1;
        $display("txn illegal op");

        // ---- sw wraparound and async reset in MEM ----
        do_reset();
        dp_if.op = 6'b101011;
        run = 1'b1;
        for (int i = 0; i < 1500 && instr_count != 8'd255; i++) tick();
        check_val("sw_reach_255", instr_count, 255);
        check_val("sw_fetch", state, 1);
        tick(); tick(); tick();
        check_val("sw_mem", state, 4);
        check_val("sw_mem_we", dp_if.mem_write, 1);
        tick();
        check_val("sw_wrap", instr_count, 0);
        tick(); tick(); tick();
        check_val("sw_mem2_we", dp_if.mem_write, 1);
        #2;
        iRST_N = 1'b0;
        #1;
        check_val("sw_async_we", dp_if.mem_write, 0);
        check_val("sw_async_state", state, 0);
        run = 1'b0;
        tick();
        iRST_N = 1'b1;
        $display("txn sw wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
